// File: rtl/matrix_write_sequencer.sv
// ----------------------------------------------------------------------------
// matrix_write_sequencer
//
// Purpose: loads one matrix at a time into the matrix storage block. A load
// command (rows x cols) allocates the next matrix ID. A valid/ready stream of
// 4-bit elements is then accepted, and each element is driven onto the
// storage write port in row-major order. This block is the only writer of
// the storage.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   start, cfg_rows, cfg_cols  load request and dimensions (sampled in IDLE)
//   abort                      cancels a load in progress
//   elem_valid, elem_data      element stream in
//   elem_ready                 element stream ready (high in LOAD)
//   mem_full                   storage full flag (sampled only at start)
//   mem_we, mem_matrix_id,
//   mem_rows, mem_cols,
//   mem_addr_row, mem_addr_col,
//   mem_data                   registered storage write port
//   busy                       high while loading
//   done, alloc_id             completion pulse and ID of last completed matrix
//   err, err_code              error pulse and sticky cause
//                              (01 dims, 10 full, 11 abort)
// ----------------------------------------------------------------------------
module matrix_write_sequencer #(
  parameter int MAX_DIM = 5,
  parameter int NUM_IDS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] cfg_rows,
  input  logic [2:0] cfg_cols,
  input  logic       abort,
  input  logic       elem_valid,
  input  logic [3:0] elem_data,
  output logic       elem_ready,
  input  logic       mem_full,
  output logic       mem_we,
  output logic [2:0] mem_matrix_id,
  output logic [2:0] mem_rows,
  output logic [2:0] mem_cols,
  output logic [2:0] mem_addr_row,
  output logic [2:0] mem_addr_col,
  output logic [3:0] mem_data,
  output logic       busy,
  output logic       done,
  output logic [2:0] alloc_id,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [2:0] MAX_DIM_V = 3'(MAX_DIM);
  localparam logic [2:0] LAST_ID   = 3'(NUM_IDS - 1);

  state_t     state;
  logic [2:0] row;
  logic [2:0] col;
  logic [2:0] next_id;

  logic       bad_dims;
  logic       handshake;

  assign bad_dims  = (cfg_rows == 3'd0) || (cfg_rows > MAX_DIM_V) ||
                     (cfg_cols == 3'd0) || (cfg_cols > MAX_DIM_V);

  // busy and elem_ready are pure decodes of the state register, so they
  // change on the same edge as the state itself.
  assign busy       = (state == LOAD);
  assign elem_ready = (state == LOAD);
  assign handshake  = elem_valid & elem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      row           <= 3'd0;
      col           <= 3'd0;
      next_id       <= 3'd0;
      mem_we        <= 1'b0;
      mem_matrix_id <= 3'd0;
      mem_rows      <= 3'd0;
      mem_cols      <= 3'd0;
      mem_addr_row  <= 3'd0;
      mem_addr_col  <= 3'd0;
      mem_data      <= 4'd0;
      done          <= 1'b0;
      alloc_id      <= 3'd0;
      err           <= 1'b0;
      err_code      <= 2'b00;
    end else begin
      // Pulse outputs default low; they are set on the edge entering the
      // state in which they are meant to be visible.
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            // Dimension errors are reported in preference to storage-full.
            if (bad_dims) begin
              err      <= 1'b1;
              err_code <= 2'b01;
              state    <= ERR;
            end else if (mem_full) begin
              err      <= 1'b1;
              err_code <= 2'b10;
              state    <= ERR;
            end else begin
              mem_rows      <= cfg_rows;
              mem_cols      <= cfg_cols;
              mem_matrix_id <= next_id;
              row           <= 3'd0;
              col           <= 3'd0;
              state         <= LOAD;
            end
          end
        end

        LOAD: begin
          // Abort wins over a same-cycle handshake: that element is dropped.
          // next_id is left alone so the next load reuses this ID.
          if (abort) begin
            err      <= 1'b1;
            err_code <= 2'b11;
            state    <= ERR;
          end else if (handshake) begin
            mem_we       <= 1'b1;
            mem_addr_row <= row;
            mem_addr_col <= col;
            mem_data     <= elem_data;
            if (col == mem_cols - 3'd1) begin
              col <= 3'd0;
              if (row == mem_rows - 3'd1) begin
                // Last element: done coincides with its write pulse.
                done     <= 1'b1;
                alloc_id <= mem_matrix_id;
                state    <= DONE;
              end else begin
                row <= row + 3'd1;
              end
            end else begin
              col <= col + 3'd1;
            end
          end
        end

        DONE: begin
          next_id <= (next_id == LAST_ID) ? 3'd0 : next_id + 3'd1;
          state   <= IDLE;
        end

        ERR: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_write_sequencer.sv
module tb_matrix_write_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] cfg_rows;
  logic [2:0] cfg_cols;
  logic       abort;
  logic       elem_valid;
  logic [3:0] elem_data;
  logic       elem_ready;
  logic       mem_full;
  logic       mem_we;
  logic [2:0] mem_matrix_id;
  logic [2:0] mem_rows;
  logic [2:0] mem_cols;
  logic [2:0] mem_addr_row;
  logic [2:0] mem_addr_col;
  logic [3:0] mem_data;
  logic       busy;
  logic       done;
  logic [2:0] alloc_id;
  logic       err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  matrix_write_sequencer #(.MAX_DIM(5), .NUM_IDS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .abort(abort), .elem_valid(elem_valid), .elem_data(elem_data),
    .elem_ready(elem_ready), .mem_full(mem_full), .mem_we(mem_we),
    .mem_matrix_id(mem_matrix_id), .mem_rows(mem_rows), .mem_cols(mem_cols),
    .mem_addr_row(mem_addr_row), .mem_addr_col(mem_addr_col), .mem_data(mem_data),
    .busy(busy), .done(done), .alloc_id(alloc_id), .err(err), .err_code(err_code)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every storage write seen, in order.
  typedef struct {
    int w_row;
    int w_col;
    int w_data;
    int w_id;
  } wr_t;
  wr_t wq[$];
  int  done_cnt = 0;
  int  err_cnt  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) wq.push_back('{int'(mem_addr_row), int'(mem_addr_col),
                                 int'(mem_data), int'(mem_matrix_id)});
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
  end

  // Reference state: only the ID allocator needs remembering between loads.
  int model_next_id = 0;

  function automatic int model_code(input int r, input int c, input bit full);
    if (r < 1 || r > 5 || c < 1 || c > 5) return 1;
    if (full) return 2;
    return 0;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_we"}, int'(mem_we), 0);
    chk({tag, "_ready"},  int'(elem_ready), 0);
    chk({tag, "_busy"},   int'(busy), 0);
    chk({tag, "_done"},   int'(done), 0);
    chk({tag, "_err"},    int'(err), 0);
    chk({tag, "_code"},   int'(err_code), 0);
    chk({tag, "_alloc"},  int'(alloc_id), 0);
    chk({tag, "_id"},     int'(mem_matrix_id), 0);
    chk({tag, "_dims"},   int'({mem_rows, mem_cols}), 0);
    chk({tag, "_addr"},   int'({mem_addr_row, mem_addr_col}), 0);
    chk({tag, "_data"},   int'(mem_data), 0);
  endtask

  // One complete load transaction. vpct < 0 means valid toggles every
  // other cycle. abort_after >= 0 asserts abort (with valid) on that element.
  task automatic run_load(input int r, input int c, input bit full,
                          input int abort_after, input int vpct,
                          input bit seq_data, input int exp_code, input int exp_id);
    logic [3:0] dat[25];
    int k, cyc, n, done0;
    bit aborted;
    wq.delete();
    done0   = done_cnt;
    aborted = 0;
    for (int i = 0; i < 25; i++) dat[i] = seq_data ? 4'(i + 1) : 4'($urandom);

    @(negedge clk);
    start = 1; cfg_rows = r[2:0]; cfg_cols = c[2:0]; mem_full = full;
    @(negedge clk);
    start = 0; mem_full = 1'($urandom);  // must be ignored from here on

    if (exp_code != 0) begin
      chk("rej_err", int'(err), 1);
      chk("rej_code", int'(err_code), exp_code);
      chk("rej_busy", int'(busy), 0);
      @(negedge clk);
      chk("rej_err_clr", int'(err), 0);
      chk("rej_writes", wq.size(), 0);
      $display("load %0dx%0d full=%0d -> rejected code=%0d", r, c, full, exp_code);
      return;
    end

    chk("ld_busy", int'(busy), 1);
    chk("ld_ready", int'(elem_ready), 1);

    k = 0; cyc = 0;
    forever begin
      if (cyc > 400) begin
        chk("stream_timeout", k, r * c);
        break;
      end
      elem_valid = (vpct < 0) ? ((cyc % 2) == 0) : ($urandom_range(99) < vpct);
      elem_data  = dat[k];
      abort      = 0;
      if (abort_after == k) begin abort = 1; elem_valid = 1; end
      // Stray start during LOAD must be ignored.
      start    = ($urandom_range(3) == 0);
      cfg_rows = 3'($urandom); cfg_cols = 3'($urandom);
      @(negedge clk);
      cyc++;
      if (abort) begin aborted = 1; break; end
      if (elem_valid) begin
        k++;
        if (k == r * c) break;
      end
    end
    start = 0; elem_valid = 0; abort = 0;

    if (aborted) begin
      n = abort_after;
      chk("ab_err", int'(err), 1);
      chk("ab_code", int'(err_code), 3);
      chk("ab_busy", int'(busy), 0);
      chk("ab_done", int'(done), 0);
    end else begin
      n = r * c;
      model_next_id = (model_next_id + 1) % 8;
      chk("dn_done", int'(done), 1);
      chk("dn_alloc", int'(alloc_id), exp_id);
      chk("dn_last_we", int'(mem_we), 1);
      chk("dn_ready", int'(elem_ready), 0);
    end
    abort = 1'($urandom);  // outside LOAD: ignored
    @(negedge clk);
    abort = 0;
    chk("end_busy", int'(busy), 0);
    chk("end_err", int'(err), aborted ? 0 : 0);
    chk("end_done", int'(done), 0);
    chk("end_id_hold", int'(mem_matrix_id), exp_id);
    chk("end_dims_hold", int'({mem_rows, mem_cols}), (r << 3) | c);
    chk("done_pulses", done_cnt - done0, aborted ? 0 : 1);
    chk("write_count", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      chk("wr_row",  wq[i].w_row,  i / c);
      chk("wr_col",  wq[i].w_col,  i % c);
      chk("wr_data", wq[i].w_data, int'(dat[i]));
      chk("wr_id",   wq[i].w_id,   exp_id);
    end
    $display("load %0dx%0d id=%0d writes=%0d %s", r, c, exp_id, wq.size(),
             aborted ? "aborted" : "completed");
  endtask

  typedef struct {
    int rows;
    int cols;
    bit full;
    int abort_after;
    int vpct;
    int exp_code;
    int exp_id;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int r, c, ab, code;
    bit full;
    tbl[0] = '{0, 3, 0, -1, 100, 1, 0};
    tbl[1] = '{3, 6, 0, -1, 100, 1, 0};
    tbl[2] = '{2, 3, 0, -1, 100, 0, 0};
    tbl[3] = '{3, 3, 1, -1, 100, 2, 1};
    tbl[4] = '{0, 2, 1, -1, 100, 1, 1};
    tbl[5] = '{3, 3, 0,  4, 100, 0, 1};
    tbl[6] = '{1, 1, 0, -1, 100, 0, 1};
    tbl[7] = '{5, 5, 0, -1,  -1, 0, 2};

    rst = 1; start = 0; cfg_rows = 0; cfg_cols = 0; abort = 0;
    elem_valid = 0; elem_data = 0; mem_full = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 0;

    for (int i = 0; i < 8; i++)
      run_load(tbl[i].rows, tbl[i].cols, tbl[i].full, tbl[i].abort_after,
               tbl[i].vpct, 1'b1, tbl[i].exp_code, tbl[i].exp_id);

    // Reset in the middle of a 5x5 load.
    begin
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      start = 1; cfg_rows = 5; cfg_cols = 5; mem_full = 0;
      @(negedge clk);
      start = 0;
      for (int i = 0; i < 7; i++) begin
        elem_valid = 1; elem_data = 4'(i + 3);
        @(negedge clk);
      end
      rst = 1;
      #1;
      chk_zero("midrst");
      elem_valid = 0;
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_idle", int'(busy), 0);
      model_next_id = 0;
      $display("reset asserted mid-load after 7 elements");
    end

    // Nine 1x1 loads: IDs 0..7 then wrap to 0.
    for (int i = 0; i < 9; i++) run_load(1, 1, 0, -1, 100, 1'b0, 0, i % 8);

    // Random loads against the reference rules.
    for (int i = 0; i < 30; i++) begin
      r    = $urandom_range(7);
      c    = $urandom_range(7);
      full = ($urandom_range(3) == 0);
      code = model_code(r, c, full);
      ab   = -1;
      if (code == 0 && $urandom_range(4) == 0) ab = $urandom_range(r * c - 1);
      run_load(r, c, full, ab, 30 + $urandom_range(70), 1'b0, code, model_next_id);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_write_sequencer.md
# matrix_write_sequencer

Sequences the loading of one matrix at a time into the matrix storage block. It accepts a load command (dimensions), allocates a matrix ID, accepts a valid/ready stream of 4-bit elements, and drives the storage write port in row-major order. It sits between the UART/keypad input parser and the matrix storage block, and is the only writer of that storage.

## Interface
- MAX_DIM, 5, largest legal row/column count; legal dimensions are 1..MAX_DIM.
- NUM_IDS, 8, number of matrix IDs; IDs wrap modulo NUM_IDS.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  load request; sampled only in IDLE.
- cfg_rows  in  3  row count of the matrix to load.
- cfg_cols  in  3  column count of the matrix to load.
- abort  in  1  cancels a load in progress.
- elem_valid  in  1  element stream valid.
- elem_data  in  4  element value.
- elem_ready  out  1  element stream ready.
- mem_full  in  1  storage full flag from the storage block.
- mem_we  out  1  storage write enable (registered).
- mem_matrix_id  out  3  target matrix ID.
- mem_rows, mem_cols  out  3 each  latched dimensions.
- mem_addr_row, mem_addr_col  out  3 each  element address.
- mem_data  out  4  element value.
- busy  out  1  high while in LOAD.
- done  out  1  one-cycle pulse when a matrix completes.
- alloc_id  out  3  ID of the last completed matrix.
- err  out  1  one-cycle error pulse.
- err_code  out  2  00 none, 01 illegal dimensions, 10 storage full, 11 aborted. Held until the next err pulse.

## Operation
- States: IDLE, LOAD, DONE, ERR.
- IDLE, start=1:
  - cfg_rows or cfg_cols equal to 0 or greater than MAX_DIM: go to ERR, err_code=01.
  - Otherwise, mem_full=1: go to ERR, err_code=10. Dimension errors take priority over storage-full.
  - Otherwise: latch the dimensions, set cur_id=next_id, clear the row/col counters, go to LOAD.
- LOAD:
  - elem_ready=1.
  - Each handshake (elem_valid & elem_ready) registers mem_we=1 with the current row/col and elem_data.
  - Column increments; at cols-1 it wraps to 0 and the row increments.
  - The handshake at (rows-1, cols-1) moves the state to DONE.
- DONE (one cycle):
  - done=1, alloc_id=cur_id.
  - next_id=(next_id+1) mod NUM_IDS.
  - Go to IDLE.
- ERR (one cycle): err=1, go to IDLE.
- abort in LOAD:
  - Takes priority over a same-cycle handshake; that element is not written.
  - Go to ERR with err_code=11.
  - next_id is unchanged; partially written elements are left in storage and are overwritten by the next load.
- abort outside LOAD is ignored. start outside IDLE is ignored.
- mem_full is sampled only at start and is ignored during LOAD.
- mem_matrix_id, mem_rows and mem_cols hold their latched values outside LOAD.

## Timing
- Reset values: all outputs 0, next_id=0, state IDLE. This applies immediately on rst assertion, including mid-LOAD; no done or err pulse is generated.
- start accepted at cycle t:
  - Valid command: LOAD from t+1, elem_ready=1 from t+1.
  - Rejected command: err=1 at t+1, IDLE at t+2.
- Handshake at cycle n: mem_we=1 in cycle n+1 only, with the address and data of that element.
- Last handshake at n: final mem_we and done both high at n+1; elem_ready=0 at n+1; IDLE at n+2, where start is accepted again.
- busy equals (state==LOAD).
- Throughput: one element per cycle. Minimum load time for an R×C matrix is R·C+2 cycles from start to IDLE.

## Test plan
- Load a 2×3 matrix with continuous valid, data 1..6 → six mem_we pulses at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with data 1..6, mem_matrix_id=0; done with alloc_id=0 at the cycle of the 6th write.
- Nine 1×1 loads back to back → alloc_id sequence 0..7 then 0 (ID wrap).
- start with rows=0, then cols=6 → err with err_code=01 each time, no mem_we, next load still gets ID 0.
- start with a legal 3×3 and mem_full=1 → err_code=10. Illegal dimensions with mem_full=1 → err_code=01.
- 3×3 load, abort after 4 elements with elem_valid high in the same cycle → exactly 4 writes, err_code=11, next load reuses the same ID.
- 5×5 load with elem_valid toggling every other cycle → 25 writes, correct row-major addresses; rst mid-load clears all outputs, gives no done pulse, and the next load gets ID 0.
